// File: rtl/uart_rx_led_pkg.sv
// Shared definitions for the USB-serial UART receiver: frame format,
// default baud divisor and receiver state encoding.
package uart_rx_led_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 100;  // 100 MHz clock, 1 Mbaud

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = IDLE,
        ST_START = START,
        ST_DATA  = DATA,
        ST_STOP  = STOP,
        ST_BREAK = BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_led_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs; the reset value
// is a parameter so idle-high lines come out of reset idle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= {2{RST_VAL}};
        else     sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_led.sv
// UART 8N1 receiver: strobes each good byte out on rx_data/rx_valid and
// latches it onto the LEDs; a low stop bit gives a single frame_err strobe.
module uart_rx_led
    import uart_rx_led_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter logic [7:0] LED_INIT     = 8'hfc
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usb_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [7:0] led,
    output logic       busy
);

    localparam int                 CNT_W     = $clog2(CLKS_PER_BIT) + 1;
    localparam int                 IDX_W     = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]   LAST_BIT  = IDX_W'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]                data_q, data_d;
    logic [7:0]                led_q, led_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (usb_rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= 8'h00;
            led_q     <= LED_INIT;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            led_q     <= led_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        led_d     = led_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT) state_d = ST_STOP;
                    else                       bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            ST_STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        led_d   = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                clk_cnt_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign led       = led_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_led.sv
// Directed bench for uart_rx_led at 16 clocks per bit: reset, false start,
// good/bad frames, back-to-back frames, mid-frame reset and +/-3% baud skew.
`timescale 1ns/1ps
module tb_uart_rx_led;

    localparam int CPB    = 16;
    localparam int BIT_NS = CPB * 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       usb_rx = 1'b1;
    logic [7:0] rx_data, led;
    logic       rx_valid, frame_err, busy;

    int         total = 0;
    int         bad = 0;
    int         nvalid = 0;
    int         nferr = 0;
    int         nboth = 0;
    logic [7:0] rxq[$];

    uart_rx_led #(.CLKS_PER_BIT(CPB), .LED_INIT(8'hfc)) dut (
        .clk       (clk),
        .rst       (rst),
        .usb_rx    (usb_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .led       (led),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            nvalid <= nvalid + 1;
            rxq.push_back(rx_data);
        end
        if (frame_err) nferr <= nferr + 1;
        if (rx_valid && frame_err) nboth <= nboth + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start bit, 8 data bits LSB first, stop bit (stretched by extra_low if low)
    task automatic send_frame(input logic [7:0] b, input logic stop, input int per, input int extra_low);
        usb_rx = 1'b0;
        #(per);
        for (int i = 0; i < 8; i++) begin
            usb_rx = b[i];
            #(per);
        end
        usb_rx = stop;
        #(per + (stop ? 0 : extra_low));
        usb_rx = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic [7:0] c3;
        int         v0, f0, errs, per;

        // Reset values
        rst = 1'b1;
        usb_rx = 1'b1;
        idle(3);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_led", led, 8'hfc);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(5);
        chk("idle_busy", busy, 1'b0);

        // False start: 4-clock low glitch
        v0 = nvalid; f0 = nferr;
        @(negedge clk);
        usb_rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy_hi", busy, 1'b1);
        usb_rx = 1'b1;
        idle(10);
        chk("glitch_busy_lo", busy, 1'b0);
        chk("glitch_nvalid", nvalid - v0, 0);
        chk("glitch_nferr", nferr - f0, 0);
        chk("glitch_led", led, 8'hfc);

        // Single good byte
        v0 = nvalid; f0 = nferr;
        send_frame(8'hA5, 1'b1, BIT_NS, 0);
        idle(20);
        chk("a5_nvalid", nvalid - v0, 1);
        chk("a5_byte", rxq[v0], 8'hA5);
        chk("a5_rx_data_held", rx_data, 8'hA5);
        chk("a5_led", led, 8'hA5);
        chk("a5_nferr", nferr - f0, 0);
        chk("a5_busy", busy, 1'b0);

        // Low stop bit followed by a 40-clock break, then a good byte
        v0 = nvalid; f0 = nferr;
        send_frame(8'h3C, 1'b0, BIT_NS, 400);
        idle(20);
        chk("ferr_count", nferr - f0, 1);
        chk("ferr_nvalid", nvalid - v0, 0);
        chk("ferr_led", led, 8'hA5);
        chk("ferr_rx_data", rx_data, 8'hA5);
        chk("ferr_busy", busy, 1'b0);
        send_frame(8'h81, 1'b1, BIT_NS, 0);
        idle(20);
        chk("after_ferr_nvalid", nvalid - v0, 1);
        chk("after_ferr_byte", rxq[v0], 8'h81);
        chk("after_ferr_led", led, 8'h81);
        chk("after_ferr_nferr", nferr - f0, 1);

        // Back-to-back frames with single stop bits
        v0 = nvalid; f0 = nferr;
        send_frame(8'h00, 1'b1, BIT_NS, 0);
        send_frame(8'hFF, 1'b1, BIT_NS, 0);
        send_frame(8'h55, 1'b1, BIT_NS, 0);
        idle(20);
        chk("b2b_nvalid", nvalid - v0, 3);
        chk("b2b_byte0", rxq[v0], 8'h00);
        chk("b2b_byte1", rxq[v0+1], 8'hFF);
        chk("b2b_byte2", rxq[v0+2], 8'h55);
        chk("b2b_led", led, 8'h55);
        chk("b2b_nferr", nferr - f0, 0);

        // Reset during bit 4 of 0xC3, host idles the line
        v0 = nvalid; f0 = nferr;
        c3 = 8'hC3;
        usb_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            usb_rx = c3[i];
            #(BIT_NS);
        end
        usb_rx = c3[4];
        #(BIT_NS / 2);
        @(negedge clk);
        chk("midrst_busy_before", busy, 1'b1);
        rst = 1'b1;
        usb_rx = 1'b1;
        idle(1);
        chk("midrst_led", led, 8'hfc);
        chk("midrst_rx_data", rx_data, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rx_valid", rx_valid, 1'b0);
        chk("midrst_frame_err", frame_err, 1'b0);
        rst = 1'b0;
        idle(40);
        chk("midrst_nvalid", nvalid - v0, 0);
        send_frame(8'h5A, 1'b1, BIT_NS, 0);
        idle(20);
        chk("midrst_next_nvalid", nvalid - v0, 1);
        chk("midrst_next_byte", rxq[v0], 8'h5A);
        chk("midrst_next_led", led, 8'h5A);
        chk("midrst_nferr", nferr - f0, 0);

        // Baud skew of -3% and +3% against the receiver's bit period
        for (int r = 0; r < 2; r++) begin
            per = (r == 0) ? 155 : 165;
            v0 = nvalid; f0 = nferr;
            exp_q.delete();
            for (int i = 0; i < 128; i++) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                send_frame(b, 1'b1, per, 0);
            end
            idle(20);
            chk("skew_nvalid", nvalid - v0, 128);
            errs = 0;
            for (int i = 0; i < 128; i++)
                if (rxq[v0+i] !== exp_q[i]) errs++;
            chk("skew_data_errs", errs, 0);
            chk("skew_nferr", nferr - f0, 0);
        end

        chk("valid_ferr_overlap", nboth, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
